// File: rtl/lfsr_20_sync_checker.sv
// Sync checker for a 20-bit Fibonacci LFSR stream (x^20+x^17+1).
// Acquires, verifies and then flywheels on its own prediction while counting errors.
module lfsr_20_sync_checker #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        bit_vld,
  input  logic        bit_in,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

  state_t      st_q, st_d;
  logic [19:0] h_q, h_d;
  logic [4:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic        err_d;
  logic [15:0] errc_d;

  logic        p;
  logic [19:0] h_acq;
  logic [19:0] h_fly;

  assign p     = h_q[19] ^ h_q[16];
  assign h_acq = {h_q[18:0], bit_in};
  assign h_fly = {h_q[18:0], p};

  always_comb begin
    st_d    = st_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    errc_d  = err_count;
    if (bit_vld) begin
      unique case (st_q)
        ACQ: begin
          h_d = h_acq;
          if (fill_q == 5'd19) begin
            fill_d = 5'd0;
            // an all-zero history would predict zeros forever
            if (h_acq != 20'd0) begin
              st_d    = VERIFY;
              match_d = 8'd0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          h_d = h_fly;
          if (bit_in == p) begin
            if (match_q + 8'd1 == LOCK_N) begin
              st_d    = LOCKED;
              match_d = 8'd0;
              miss_d  = 8'd0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            st_d    = ACQ;
            fill_d  = 5'd0;
            match_d = 8'd0;
          end
        end
        LOCKED: begin
          h_d = h_fly;
          if (bit_in != p) begin
            err_d = 1'b1;
            if (err_count != 16'hFFFF)
              errc_d = err_count + 16'd1;
            if (miss_q + 8'd1 == LOSS_N) begin
              st_d    = ACQ;
              fill_d  = 5'd0;
              match_d = 8'd0;
              miss_d  = 8'd0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = 8'd0;
          end
        end
        default: begin
          st_d   = ACQ;
          fill_d = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st_q      <= ACQ;
      h_q       <= 20'd0;
      fill_q    <= 5'd0;
      match_q   <= 8'd0;
      miss_q    <= 8'd0;
      err       <= 1'b0;
      err_count <= 16'd0;
    end else begin
      st_q      <= st_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err       <= err_d;
      err_count <= errc_d;
    end
  end

  assign state  = st_q;
  assign locked = (st_q == LOCKED);

endmodule

// File: doc/lfsr_20_sync_checker.md
LFSR_20_SYNC_CHECKER -- requirements
Module: lfsr_20_sync_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16, meaning consecutive correct predictions in VERIFY required to declare lock (legal 1..255).
REQ-002 Parameter LOSS_CNT, default 4, meaning consecutive mispredictions in LOCKED that force loss of lock (legal 1..255).
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 bit_vld  input  1  qualifies bit_in; the block advances only on cycles with bit_vld=1.
REQ-006 bit_in  input  1  received serial bit from a 20-bit Fibonacci LFSR transmitter (polynomial x^20+x^17+1).
REQ-007 locked  output  1  registered; high while in state LOCKED.
REQ-008 err  output  1  registered single-cycle pulse for a misprediction in LOCKED.
REQ-009 err_count  output  16  registered total mispredictions in LOCKED, saturating.
REQ-010 state  output  2  registered FSM state: 0=ACQ, 1=VERIFY, 2=LOCKED; 3 is never driven.

Function
REQ-011 Internal 20-bit history h: h[0] newest bit, h[19] oldest; every update is a shift {h[18:0], new}.
REQ-012 Predicted bit p = h[19] XOR h[16], i.e. b[n] = b[n-20] XOR b[n-17].
REQ-013 Cycles with bit_vld=0 leave every register unchanged, and err is 0 on the following cycle.
REQ-014 ACQ: each valid bit shifts bit_in into h; a 5-bit fill counter increments; no comparison is made.
REQ-015 ACQ, 20th valid bit: if the resulting h is nonzero, go to VERIFY with the match counter at 0; if it is all-zero, stay in ACQ with the fill counter at 0.
REQ-016 VERIFY: each valid bit compares bit_in to p; h shifts in p (flywheel), never bit_in.
REQ-017 VERIFY match: the 8-bit match counter increments; the match that reaches LOCK_CNT moves to LOCKED.
REQ-018 VERIFY mismatch: return to ACQ, clear the fill and match counters, and count no error.
REQ-019 LOCKED: each valid bit compares bit_in to p; h shifts in p; bit_in never enters h.
REQ-020 LOCKED mismatch: err=1 for one cycle; err_count increments, holding at 16'hFFFF; the 8-bit miss counter increments.
REQ-021 LOCKED match: the miss counter clears.
REQ-022 LOCKED: the mismatch that brings the miss counter to LOSS_CNT still pulses err and counts, then goes to ACQ with all counters except err_count cleared.
REQ-023 Latency: the outputs for a valid bit sampled at edge k are visible after edge k; there is no further pipeline.
REQ-024 err_count is never cleared except by reset, including across lock loss and reacquisition.
REQ-025 locked and state are derived from the registered FSM state and change on the same edge as the transition.

Reset
REQ-026 While nRST=0 at a rising edge, the block sets state=ACQ, h=0, all counters=0, locked=0, err=0 and err_count=0, regardless of bit_vld.
REQ-027 Reset asserted mid-operation in any state takes priority over that cycle's bit, and acquisition restarts from an empty fill.
REQ-028 After release, the first valid bit is fill bit 1 of 20.

Verification
REQ-029 Feed a golden LFSR seeded 20'hDBEEF continuously with bit_vld=1 -> state=VERIFY after the 20th bit; locked=1 after the 36th bit; err_count stays 0 for 10000 bits.
REQ-030 Locked stream, invert one bit -> err pulses exactly one cycle; err_count=1; locked stays 1. The following correct bits produce no further errors, confirming the flywheel.
REQ-031 Locked stream, invert 4 consecutive bits -> 4 err pulses, err_count=4, state=ACQ after the 4th; the stream resumes clean and locked=1 again 36 valid bits later, with err_count still 4.
REQ-032 Golden stream with bit_vld toggling 1,0,1,0 -> identical lock point counted in valid bits (36); err=0 on all idle cycles.
REQ-033 Feed 20 zeros -> state stays ACQ, then a clean seeded stream locks after 36 further bits. Also inject one error at VERIFY bit 5 -> state=ACQ, err_count=0.
REQ-034 Assert nRST for one cycle while LOCKED with err_count=7 -> all outputs 0, state=ACQ; relock takes 36 valid bits.
